mmap_apb_bridge: RTL and testbench
==================================

Name: mmap_apb_bridge

Overview:
Parametrised successor to the fixed 8-slave mem2apb bridge. It converts the core's valid/ready memory-mapped request into APB4 transfers to SLV_NUM slaves. Slave address windows come from base/mask parameters instead of being hard-coded. Adds decode-error responses, a per-access PREADY timeout, an error flag back to the master and a saturating error counter. Sits between the core's peripheral mmap port and the APB peripheral cluster (archinfo, rng, uart, pwm, ps2, i2c, qspi, spi flash, ...).

Parameters:
SLV_NUM, 8, number of APB slaves (1..32)
BASE_ADDR, {SLV_NUM{32'h0}}, packed SLV_NUM*32 slave base addresses; slave i at bits [32*i+:32]
ADDR_MASK, {SLV_NUM{32'hFFFF_F000}}, packed SLV_NUM*32 decode masks
TIMEOUT, 255, max ACCESS cycles waiting for PREADY; 0 disables the timeout
DECERR_RDATA, 32'hDEAD_BEEF, read data returned on a decode error or timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
mmap_valid_i  in  1  request valid; held by the master until mmap_ready_o
mmap_addr_i  in  32  byte address
mmap_wdata_i  in  32  write data
mmap_wstrb_i  in  4  byte strobes; 0 = read
mmap_rdata_o  out  32  read data, valid while mmap_ready_o is high
mmap_ready_o  out  1  one-cycle completion pulse
mmap_err_o  out  1  error qualifier, valid with mmap_ready_o
apb_paddr_o  out  32  APB address
apb_pprot_o  out  3  fixed 3'b010
apb_psel_o  out  SLV_NUM  one-hot select
apb_penable_o  out  1  APB enable
apb_pwrite_o  out  1  APB write
apb_pwdata_o  out  32  APB write data
apb_pstrb_o  out  4  APB strobes
apb_pready_i  in  SLV_NUM  per-slave PREADY
apb_prdata_i  in  SLV_NUM*32  per-slave PRDATA; slave i at bits [32*i+:32]
apb_pslverr_i  in  SLV_NUM  per-slave PSLVERR
err_cnt_o  out  16  saturating error count

Behaviour:
- All outputs are registered. The reset value of every output is 0, applied on the first clk_i edge with rst_i high.
- States: IDLE, SETUP, ACCESS, RESP.
- Decode (combinational on mmap_addr_i): hit[i] = ((addr & ADDR_MASK[i]) == BASE_ADDR[i]). The lowest hit index wins.
- IDLE with mmap_valid_i high:
  - Hit: go to SETUP. Latch paddr = addr and pwdata = wdata. Set pwrite = |wstrb. Set pstrb = wstrb for a write, 4'h0 for a read. Set psel = onehot(idx). penable = 0.
  - Miss: go to RESP with err = 1 and rdata = DECERR_RDATA (writes discarded). No APB activity.
- SETUP: penable set to 1. Go to ACCESS and clear the timeout counter.
- ACCESS, pready[idx] = 1:
  - Capture rdata = prdata[idx] (reads only; writes give 0) and err = pslverr[idx].
  - Clear psel and penable. Go to RESP.
- ACCESS, pready[idx] = 0:
  - Increment the timeout counter (8-bit minimum, width $clog2(TIMEOUT+1)).
  - When the counter == TIMEOUT and TIMEOUT != 0: clear psel and penable, err = 1, rdata = DECERR_RDATA, go to RESP.
- RESP: mmap_ready_o = 1 for exactly one cycle, then IDLE. The next request can be accepted on the cycle after RESP.
- Latency from the valid-sampling edge to the ready pulse:
  - decode miss: 1 cycle;
  - zero-wait slave: 3 cycles;
  - slave with N wait states: 3+N cycles.
- paddr, pwdata, pwrite and pstrb are stable from SETUP through ACCESS. They hold their last values in IDLE.
- Only the selected slave's pready, prdata and pslverr are observed. Other slaves' signals are ignored.
- err_cnt_o increments by 1 for each RESP with err = 1. It saturates at 16'hFFFF and is cleared only by reset.
- Reset mid-operation: psel and penable drop at the reset edge; state returns to IDLE; no ready pulse is issued.
- Address and strobes are passed through unaligned, with no alignment checks.
- mmap_valid_i dropping before ready is a protocol violation; the bridge completes the transfer anyway.

Decomposition:
- Package apb_bridge_pkg: state enum (IDLE, SETUP, ACCESS, RESP), APB_PPROT_DEFAULT = 3'b010, DECERR_RDATA_DEFAULT.
- Sub-module apb_addr_decoder (parameters SLV_NUM, BASE_ADDR, ADDR_MASK):
  - combinational;
  - outputs hit, idx [$clog2(SLV_NUM)] and onehot [SLV_NUM], with lowest-index priority.

Test Plan:
- Read from slave 2 (base 0x0300_2000), zero-wait, prdata2 = 0x1234_5678 -> psel = 8'h04, penable on the 2nd cycle, mmap_ready 3 cycles after valid, rdata = 0x1234_5678, err = 0.
- Write 0xA5A5_0000 with wstrb = 4'b1100 to slave 5, PREADY delayed 4 cycles -> pwrite = 1, pstrb = 4'b1100, ready at 7 cycles, err = 0; read to slave 5 -> pstrb = 0.
- Access to an unmapped address -> no psel, ready 1 cycle later, rdata = 0xDEAD_BEEF, err = 1, err_cnt_o = 1.
- Slave never asserts PREADY, TIMEOUT = 16 -> psel drops after 16 ACCESS cycles, err = 1, rdata = 0xDEAD_BEEF.
- Slave returns PSLVERR = 1 -> err = 1, err_cnt_o increments; non-selected slave asserting pready/pslverr -> ignored.
- rst_i asserted in ACCESS -> psel and penable are 0 after the next edge, no ready pulse; next request completes normally; overlapping BASE/MASK windows -> lowest index selected.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the memory-mapped to APB4 bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0]  APB_PPROT_DEFAULT    = 3'b010;
  localparam logic [31:0] DECERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_addr_decoder.sv
// Base/mask address decoder; when windows overlap the lowest slave index wins.
module apb_addr_decoder #(
  parameter int                     SLV_NUM   = 8,
  parameter logic [SLV_NUM*32-1:0]  BASE_ADDR = {SLV_NUM{32'h0}},
  parameter logic [SLV_NUM*32-1:0]  ADDR_MASK = {SLV_NUM{32'hFFFF_F000}},
  parameter int                     IDX_W     = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1
) (
  input  logic [31:0]        i_addr,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_idx,
  output logic [SLV_NUM-1:0] o_onehot
);

  // Walk from the top index down so the lowest matching slave is written last.
  always_comb begin
    o_hit    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if ((i_addr & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32]) begin
        o_hit       = 1'b1;
        o_idx       = IDX_W'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmap_apb_bridge.sv
// Converts valid/ready memory-mapped requests into APB4 transfers to SLV_NUM slaves,
// with decode errors, a PREADY timeout and a saturating error counter.
module mmap_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int                     SLV_NUM      = 8,
  parameter logic [SLV_NUM*32-1:0]  BASE_ADDR    = {SLV_NUM{32'h0}},
  parameter logic [SLV_NUM*32-1:0]  ADDR_MASK    = {SLV_NUM{32'hFFFF_F000}},
  parameter int                     TIMEOUT      = 255,
  parameter logic [31:0]            DECERR_RDATA = DECERR_RDATA_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mmap_valid_i,
  input  logic [31:0]           mmap_addr_i,
  input  logic [31:0]           mmap_wdata_i,
  input  logic [3:0]            mmap_wstrb_i,
  output logic [31:0]           mmap_rdata_o,
  output logic                  mmap_ready_o,
  output logic                  mmap_err_o,
  output logic [31:0]           apb_paddr_o,
  output logic [2:0]            apb_pprot_o,
  output logic [SLV_NUM-1:0]    apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [31:0]           apb_pwdata_o,
  output logic [3:0]            apb_pstrb_o,
  input  logic [SLV_NUM-1:0]    apb_pready_i,
  input  logic [SLV_NUM*32-1:0] apb_prdata_i,
  input  logic [SLV_NUM-1:0]    apb_pslverr_i,
  output logic [15:0]           err_cnt_o
);

  localparam int IDX_W  = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int TCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TCNT_W-1:0] TIMEOUT_V = TCNT_W'(TIMEOUT);

  state_t               r_state;
  state_t               w_next_state;
  logic [31:0]          r_paddr;
  logic [31:0]          r_pwdata;
  logic                 r_pwrite;
  logic [3:0]           r_pstrb;
  logic [2:0]           r_pprot;
  logic [SLV_NUM-1:0]   r_psel;
  logic                 r_penable;
  logic [31:0]          r_rdata;
  logic                 r_ready;
  logic                 r_err;
  logic [15:0]          r_err_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [TCNT_W-1:0]    r_tcnt;

  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;
  logic [SLV_NUM-1:0]   w_onehot;
  logic                 w_sel_ready;
  logic                 w_sel_err;
  logic [31:0]          w_sel_rdata;
  logic [TCNT_W-1:0]    w_tcnt_inc;
  logic                 w_timeout;

  apb_addr_decoder #(
    .SLV_NUM   (SLV_NUM),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK),
    .IDX_W     (IDX_W)
  ) u_dec (
    .i_addr   (mmap_addr_i),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // Only the slave latched at SETUP is observed; all other slaves are ignored.
  assign w_sel_ready = apb_pready_i[r_idx];
  assign w_sel_err   = apb_pslverr_i[r_idx];
  assign w_sel_rdata = apb_prdata_i[32*r_idx +: 32];
  assign w_tcnt_inc  = r_tcnt + 1'b1;
  assign w_timeout   = (TIMEOUT != 0) && (w_tcnt_inc == TIMEOUT_V);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (mmap_valid_i) w_next_state = w_hit ? SETUP : RESP;
      SETUP:   w_next_state = ACCESS;
      ACCESS:  if (w_sel_ready || w_timeout) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_idx     <= '0;
      r_tcnt    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pprot <= APB_PPROT_DEFAULT;
      // The ready pulse coincides exactly with the RESP state.
      r_ready <= (w_next_state == RESP);
      case (r_state)
        IDLE: begin
          if (mmap_valid_i) begin
            if (w_hit) begin
              r_paddr   <= mmap_addr_i;
              r_pwdata  <= mmap_wdata_i;
              r_pwrite  <= |mmap_wstrb_i;
              r_pstrb   <= mmap_wstrb_i;
              r_psel    <= w_onehot;
              r_penable <= 1'b0;
              r_idx     <= w_idx;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= DECERR_RDATA;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_tcnt    <= '0;
        end
        ACCESS: begin
          if (w_sel_ready) begin
            r_rdata   <= r_pwrite ? 32'h0 : w_sel_rdata;
            r_err     <= w_sel_err;
            r_psel    <= '0;
            r_penable <= 1'b0;
          end else begin
            r_tcnt <= w_tcnt_inc;
            if (w_timeout) begin
              r_psel    <= '0;
              r_penable <= 1'b0;
              r_err     <= 1'b1;
              r_rdata   <= DECERR_RDATA;
            end
          end
        end
        RESP: begin
          if (r_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign mmap_rdata_o  = r_rdata;
  assign mmap_ready_o  = r_ready;
  assign mmap_err_o    = r_err;
  assign apb_paddr_o   = r_paddr;
  assign apb_pprot_o   = r_pprot;
  assign apb_psel_o    = r_psel;
  assign apb_penable_o = r_penable;
  assign apb_pwrite_o  = r_pwrite;
  assign apb_pwdata_o  = r_pwdata;
  assign apb_pstrb_o   = r_pstrb;
  assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_mmap_apb_bridge.sv
// Directed, table-driven bench for mmap_apb_bridge with a configurable-wait APB slave model.
module tb_mmap_apb_bridge;

  logic         clk;
  logic         rst;
  logic         valid;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic [31:0]  paddr;
  logic [2:0]   pprot;
  logic [7:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [7:0]   pready;
  logic [255:0] prdata;
  logic [7:0]   pslverr;
  logic [15:0]  err_cnt;

  int           wait_n;
  int           acc_cnt;
  logic [7:0]   noise;
  logic [7:0]   slverr_vec;
  int           passed;
  int           total;

  mmap_apb_bridge #(
    .SLV_NUM      (8),
    .BASE_ADDR    ({32'h0300_0000, 32'h0300_6000, 32'h0300_5000, 32'h0300_4000,
                    32'h0300_3000, 32'h0300_2000, 32'h0300_1000, 32'h0300_0000}),
    .ADDR_MASK    ({32'hFFFF_0000, {7{32'hFFFF_F000}}}),
    .TIMEOUT      (16),
    .DECERR_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mmap_valid_i  (valid),
    .mmap_addr_i   (addr),
    .mmap_wdata_i  (wdata),
    .mmap_wstrb_i  (wstrb),
    .mmap_rdata_o  (rdata),
    .mmap_ready_o  (ready),
    .mmap_err_o    (err),
    .apb_paddr_o   (paddr),
    .apb_pprot_o   (pprot),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_pwrite_o  (pwrite),
    .apb_pwdata_o  (pwdata),
    .apb_pstrb_o   (pstrb),
    .apb_pready_i  (pready),
    .apb_prdata_i  (prdata),
    .apb_pslverr_i (pslverr),
    .err_cnt_o     (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: selected slave answers after wait_n ACCESS cycles; noise drives unselected slaves.
  always_ff @(posedge clk) begin
    if (penable && (psel != 8'h00)) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end
  assign pready  = (psel & {8{penable && (acc_cnt >= wait_n)}}) | noise;
  assign pslverr = slverr_vec | noise;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          slv;
    logic [31:0] prdata;
    logic        slverr;
    int          wait_n;
    logic [7:0]  noise;
    logic [7:0]  e_psel;
    logic [3:0]  e_pstrb;
    logic        e_pwrite;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    int          e_lat;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[11];
  vec_t last_vec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int          lat;
    logic        got;
    logic [7:0]  psel_s;
    logic        pen1;
    logic        pen2;
    logic [31:0] paddr_s;
    logic [31:0] pwdata_s;
    logic        pwrite_s;
    logic [3:0]  pstrb_s;
    string       tag;
    tag = $sformatf("v%0d", n);
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      prdata[32*i +: 32] = (i == v.slv) ? v.prdata : (32'hBAD0_0000 | 32'(i));
    slverr_vec = v.slverr ? (8'h01 << v.slv) : 8'h00;
    wait_n = v.wait_n;
    noise  = v.noise;
    addr   = v.addr;
    wdata  = v.wdata;
    wstrb  = v.wstrb;
    valid  = 1'b1;
    lat = 0; got = 1'b0; pen2 = 1'b0;
    psel_s = '0; pen1 = 1'b0; paddr_s = '0; pwdata_s = '0; pwrite_s = 1'b0; pstrb_s = '0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        psel_s = psel; pen1 = penable; paddr_s = paddr;
        pwdata_s = pwdata; pwrite_s = pwrite; pstrb_s = pstrb;
      end
      if (lat == 2) pen2 = penable;
      if (ready) got = 1'b1;
    end
    chk({tag, " ready_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(v.e_lat));
    chk({tag, " rdata"}, rdata, v.e_rdata);
    chk({tag, " err"}, 32'(err), 32'(v.e_err));
    chk({tag, " psel_at_ready"}, 32'(psel), 32'h0);
    chk({tag, " psel_setup"}, 32'(psel_s), 32'(v.e_psel));
    chk({tag, " penable_setup"}, 32'(pen1), 32'h0);
    if (v.e_lat >= 3) chk({tag, " penable_access"}, 32'(pen2), 32'h1);
    chk({tag, " paddr"}, paddr_s, v.e_paddr);
    chk({tag, " pwdata"}, pwdata_s, v.e_pwdata);
    chk({tag, " pwrite"}, 32'(pwrite_s), 32'(v.e_pwrite));
    chk({tag, " pstrb"}, 32'(pstrb_s), 32'(v.e_pstrb));
    @(negedge clk);
    valid = 1'b0;
    noise = 8'h00;
    slverr_vec = 8'h00;
    @(posedge clk); #1;
    chk({tag, " ready_pulse_end"}, 32'(ready), 32'h0);
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(v.e_cnt));
  endtask

  initial begin
    logic seen;
    passed = 0; total = 0;
    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    prdata = '0; wait_n = 0; noise = 8'h00; slverr_vec = 8'h00;

    //          addr          wdata         wstrb slv prdata        serr wait noise  psel  pstrb pwr paddr         pwdata        lat rdata         err cnt
    vecs[0]  = '{32'h0300_2004, 32'h0,         4'h0, 2, 32'h1234_5678, 1'b0, 0, 8'h00, 8'h04, 4'h0, 1'b0, 32'h0300_2004, 32'h0,         3, 32'h1234_5678, 1'b0, 16'd0};
    vecs[1]  = '{32'h0300_5010, 32'hA5A5_0000, 4'hC, 5, 32'h5555_5555, 1'b0, 4, 8'h00, 8'h20, 4'hC, 1'b1, 32'h0300_5010, 32'hA5A5_0000, 7, 32'h0,         1'b0, 16'd0};
    vecs[2]  = '{32'h0300_5000, 32'h0,         4'h0, 5, 32'h0BAD_CAFE, 1'b0, 0, 8'h00, 8'h20, 4'h0, 1'b0, 32'h0300_5000, 32'h0,         3, 32'h0BAD_CAFE, 1'b0, 16'd0};
    vecs[3]  = '{32'h0400_0000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b0, 0, 8'h00, 8'h00, 4'h0, 1'b0, 32'h0300_5000, 32'h0,         1, 32'hDEAD_BEEF, 1'b1, 16'd1};
    vecs[4]  = '{32'h0300_1000, 32'h0,         4'h0, 1, 32'h1111_2222, 1'b1, 0, 8'h00, 8'h02, 4'h0, 1'b0, 32'h0300_1000, 32'h0,         3, 32'h1111_2222, 1'b1, 16'd2};
    vecs[5]  = '{32'h0300_3008, 32'h0,         4'h0, 3, 32'h3333_4444, 1'b0, 0, 8'h00, 8'h08, 4'h0, 1'b0, 32'h0300_3008, 32'h0,         3, 32'h3333_4444, 1'b0, 16'd2};
    vecs[6]  = '{32'h0300_8000, 32'h0,         4'h0, 7, 32'h7777_8888, 1'b0, 0, 8'h00, 8'h80, 4'h0, 1'b0, 32'h0300_8000, 32'h0,         3, 32'h7777_8888, 1'b0, 16'd2};
    vecs[7]  = '{32'h0300_0020, 32'hCAFE_F00D, 4'h3, 0, 32'h0000_0BAD, 1'b1, 2, 8'h00, 8'h01, 4'h3, 1'b1, 32'h0300_0020, 32'hCAFE_F00D, 5, 32'h0,         1'b1, 16'd3};
    vecs[8]  = '{32'h0300_4003, 32'h0000_00AB, 4'h1, 4, 32'h4444_4444, 1'b0, 0, 8'h00, 8'h10, 4'h1, 1'b1, 32'h0300_4003, 32'h0000_00AB, 3, 32'h0,         1'b0, 16'd3};
    vecs[9]  = '{32'h0300_2100, 32'h0,         4'h0, 2, 32'h2222_AAAA, 1'b0, 2, 8'hFB, 8'h04, 4'h0, 1'b0, 32'h0300_2100, 32'h0,         5, 32'h2222_AAAA, 1'b0, 16'd3};
    vecs[10] = '{32'h0300_6000, 32'h0,         4'h0, 6, 32'h6666_6666, 1'b0, 1000, 8'h00, 8'h40, 4'h0, 1'b0, 32'h0300_6000, 32'h0,     18, 32'hDEAD_BEEF, 1'b1, 16'd4};
    last_vec = '{32'h0300_6004, 32'h0,         4'h0, 6, 32'h6666_0001, 1'b0, 1, 8'h00, 8'h40, 4'h0, 1'b0, 32'h0300_6004, 32'h0,         4, 32'h6666_0001, 1'b0, 16'd0};

    // Reset state
    @(posedge clk); #1;
    chk("rst psel", 32'(psel), 32'h0);
    chk("rst penable", 32'(penable), 32'h0);
    chk("rst ready", 32'(ready), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst paddr", paddr, 32'h0);
    chk("rst pprot", 32'(pprot), 32'h0);
    chk("rst pwrite", 32'(pwrite), 32'h0);
    chk("rst pstrb", 32'(pstrb), 32'h0);
    chk("rst err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("pprot", 32'(pprot), 32'h2);

    for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

    // Reset while a transfer is stalled in ACCESS
    @(negedge clk);
    addr = 32'h0300_3000; wdata = '0; wstrb = '0; wait_n = 1000; valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("mid psel", 32'(psel), 32'h08);
    chk("mid penable", 32'(penable), 32'h1);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid psel", 32'(psel), 32'h0);
    chk("rstmid penable", 32'(penable), 32'h0);
    chk("rstmid ready", 32'(ready), 32'h0);
    chk("rstmid err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    chk("rstmid no_ready", 32'(seen), 32'h0);

    run_vec(last_vec, 11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
